// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - RV32I data-memory responder with wait states and access checking
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          accept;
  logic          fire;

  logic          q_we;
  logic [2:0]    q_f3;
  logic [AW+1:0] q_a;
  logic [31:0]   q_wd;

  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   word;

  logic          bad_f3;
  logic          misaligned;
  logic          acc_err;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          sx;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [31:0]   merged;

  // Only the in-range address bits are latched; the rest wrap away.
  logic          unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  localparam int unused_init_bits = $bits(INIT_FILE);

  assign widx = q_a[AW+1:2];
  assign lane = q_a[1:0];
  assign word = mem[widx];
  assign fire = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (memRead || memWrite) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unsigned loads exist, unsigned stores do not.
  always_comb begin
    case (q_f3)
      3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
      3'b100, 3'b101:         bad_f3 = q_we;
      default:                bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    case (q_f3[1:0])
      2'b01:   misaligned = q_a[0];
      2'b10:   misaligned = |q_a[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign acc_err = bad_f3 | misaligned;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = q_a[1] ? word[31:16] : word[15:0];
    sx       = ~q_f3[2];
    case (q_f3[1:0])
      2'b00:   load_val = {{24{sx & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sx & half_sel[15]}}, half_sel};
      default: load_val = word;
    endcase
  end

  // Narrow stores replicate the data across lanes and let the byte enables pick.
  always_comb begin
    case (q_f3[1:0])
      2'b00: begin
        wrep = {4{q_wd[7:0]}};
        be   = 4'b0001 << lane;
      end
      2'b01: begin
        wrep = {2{q_wd[15:0]}};
        be   = q_a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wrep = q_wd;
        be   = 4'b1111;
      end
    endcase
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      q_we    <= 1'b0;
      q_f3    <= 3'd0;
      q_a     <= '0;
      q_wd    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        q_we <= memWrite;
        q_f3 <= funct3;
        q_a  <= addr[AW+1:0];
        q_wd <= wdata;
      end
      if (fire) begin
        err_q   <= acc_err;
        rdata_q <= (!q_we && !acc_err) ? load_val : 32'd0;
      end
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && fire && q_we && !acc_err) mem[widx] <= merged;
  end

  assign ready = (state == DONE);
  assign err   = ready & err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench for data_mem_responder against a byte-level memory model
module tb_data_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [2:0]  funct3    [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        ready     [2];
  logic        err       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH      (256),
      .WAIT_CYCLES((g == 0) ? 2 : 0),
      .INIT_FILE  ("dmem.hex")
    ) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .memRead (mem_read[g]),
      .memWrite(mem_write[g]),
      .funct3  (funct3[g]),
      .addr    (addr[g]),
      .wdata   (wdata[g]),
      .rdata   (rdata[g]),
      .ready   (ready[g]),
      .err     (err[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        q_we [2];
  logic [2:0]  q_f3 [2];
  logic [31:0] q_a  [2];
  logic [31:0] q_wd [2];
  int          due        [2] = '{0, 0};
  int          issue_seq  [2] = '{0, 0};
  int          served_seq [2] = '{0, 0};
  logic [31:0] rdata_m    [2] = '{32'd0, 32'd0};
  logic [7:0]  mem_m [2][1024];
  bit          cmp_en = 1'b0;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Byte-addressed model of one completed access; returns the response data.
  function automatic logic [31:0] model_complete(input int k, output logic e);
    int          size;
    int          base;
    logic        legal;
    logic [31:0] v;
    size  = 1 << q_f3[k][1:0];
    base  = int'(q_a[k] % 32'd1024);
    legal = q_we[k] ? (q_f3[k] <= 3'd2) : (q_f3[k] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e     = !legal || (base % size != 0);
    v     = 32'd0;
    if (!e) begin
      if (q_we[k]) begin
        for (int i = 0; i < size; i++) mem_m[k][base+i] = q_wd[k][8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[k][base+i];
        if (!q_f3[k][2] && size < 4 && v[8*size-1])
          v = v | ~((32'd1 << (8*size)) - 32'd1);
      end
    end
    return v;
  endfunction

  initial begin
    logic re, ee;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        for (int k = 0; k < 2; k++) begin
          re = 1'b0;
          ee = 1'b0;
          if (rst[k]) begin
            rdata_m[k]    = 32'd0;
            served_seq[k] = issue_seq[k];
          end else if (issue_seq[k] != served_seq[k] && cyc == due[k]) begin
            rdata_m[k]    = model_complete(k, ee);
            re            = 1'b1;
            served_seq[k] = issue_seq[k];
          end
          chk($sformatf("cyc_ready%0d", k), {31'b0, ready[k]}, {31'b0, re});
          chk($sformatf("cyc_err%0d", k), {31'b0, err[k]}, {31'b0, re & ee});
          chk($sformatf("cyc_rdata%0d", k), rdata[k], rdata_m[k]);
        end
      end
    end
  end

  task automatic do_acc(input int k, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output logic ge, output int lat);
    int start;
    bit seen;
    @(negedge clk);
    mem_read[k]  = rd;
    mem_write[k] = wr;
    funct3[k]    = f3;
    addr[k]      = a;
    wdata[k]     = wd;
    q_we[k]      = wr;
    q_f3[k]      = f3;
    q_a[k]       = a;
    q_wd[k]      = wd;
    start        = cyc;
    due[k]       = cyc + wc(k) + 2;
    issue_seq[k] = issue_seq[k] + 1;
    @(negedge clk);
    // Request stays asserted; side fields change to prove they were latched.
    funct3[k] = 3'($urandom);
    addr[k]   = $urandom;
    wdata[k]  = $urandom;
    seen = 1'b0;
    got  = 32'd0;
    ge   = 1'b0;
    lat  = -1;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) begin
        seen = 1'b1;
        got  = rdata[k];
        ge   = err[k];
        lat  = cyc - start;
      end
    end
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d got no ready, required ready within 40 cycles", k);
    end
  endtask

  task automatic dir(input int k, input string name, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] got;
    logic        ge;
    int          lat;
    do_acc(k, rd, wr, f3, a, wd, got, ge, lat);
    chk({name, "_rdata"}, got, exp_rd);
    chk({name, "_err"}, {31'b0, ge}, {31'b0, exp_err});
    chk({name, "_latency"}, 32'(lat), 32'(wc(k) + 2));
  endtask

  task automatic rst_test(input int k);
    dir(k, "rst_pre_sw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE0000, 32'd0, 1'b0);
    dir(k, "rst_pre_lw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'hCAFE0000, 1'b0);
    @(negedge clk);
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b1;
    funct3[k]    = 3'b010;
    addr[k]      = 32'h40;
    wdata[k]     = 32'h1111;
    q_we[k]      = 1'b1;
    q_f3[k]      = 3'b010;
    q_a[k]       = 32'h40;
    q_wd[k]      = 32'h1111;
    due[k]       = cyc + wc(k) + 2;
    issue_seq[k] = issue_seq[k] + 1;
    // First BUSY cycle; for the zero-wait instance this edge is also BUSY->DONE.
    @(negedge clk);
    rst[k]       = 1'b1;
    mem_write[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_idle_ready", {31'b0, ready[k]}, 32'd0);
    chk("rst_idle_rdata", rdata[k], 32'd0);
    dir(k, "rst_post_lw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'hCAFE0000, 1'b0);
  endtask

  initial begin
    logic [31:0] got;
    logic        ge;
    int          lat;
    int          r;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      rst[k]       = 1'b1;
      mem_read[k]  = 1'b0;
      mem_write[k] = 1'b0;
      funct3[k]    = 3'd0;
      addr[k]      = 32'd0;
      wdata[k]     = 32'd0;
    end
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", rdata[k], 32'd0);
      chk("reset_ready", {31'b0, ready[k]}, 32'd0);
      chk("reset_err", {31'b0, err[k]}, 32'd0);
    end

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 256; w++)
        do_acc(k, 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, got, ge, lat);

    dir(0, "sw10",   1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0,        1'b0);
    dir(0, "lw10",   1'b1, 1'b0, 3'b010, 32'h10, 32'd0,        32'hDEADBEEF, 1'b0);
    dir(0, "sb11",   1'b0, 1'b1, 3'b000, 32'h11, 32'h80,       32'd0,        1'b0);
    dir(0, "lb11",   1'b1, 1'b0, 3'b000, 32'h11, 32'd0,        32'hFFFFFF80, 1'b0);
    dir(0, "lbu11",  1'b1, 1'b0, 3'b100, 32'h11, 32'd0,        32'h00000080, 1'b0);
    dir(0, "lw10b",  1'b1, 1'b0, 3'b010, 32'h10, 32'd0,        32'hDEAD80EF, 1'b0);
    dir(0, "sw20",   1'b0, 1'b1, 3'b010, 32'h20, 32'h5555AAAA, 32'd0,        1'b0);
    dir(0, "sh22",   1'b0, 1'b1, 3'b001, 32'h22, 32'h8001,     32'd0,        1'b0);
    dir(0, "lh22",   1'b1, 1'b0, 3'b001, 32'h22, 32'd0,        32'hFFFF8001, 1'b0);
    dir(0, "lhu22",  1'b1, 1'b0, 3'b101, 32'h22, 32'd0,        32'h00008001, 1'b0);
    dir(0, "lw20",   1'b1, 1'b0, 3'b010, 32'h20, 32'd0,        32'h8001AAAA, 1'b0);
    dir(0, "lw13",   1'b1, 1'b0, 3'b010, 32'h13, 32'd0,        32'd0,        1'b1);
    dir(0, "sh21",   1'b0, 1'b1, 3'b001, 32'h21, 32'h1234,     32'd0,        1'b1);
    dir(0, "lw20b",  1'b1, 1'b0, 3'b010, 32'h20, 32'd0,        32'h8001AAAA, 1'b0);
    dir(0, "ld011",  1'b1, 1'b0, 3'b011, 32'h20, 32'd0,        32'd0,        1'b1);
    dir(0, "both30", 1'b1, 1'b1, 3'b010, 32'h30, 32'h5,        32'd0,        1'b0);
    dir(0, "lw30",   1'b1, 1'b0, 3'b010, 32'h30, 32'd0,        32'h00000005, 1'b0);
    dir(0, "lwwrap", 1'b1, 1'b0, 3'b010, 32'hFFFFFC30, 32'd0,  32'h00000005, 1'b0);
    dir(1, "sb_w0",  1'b0, 1'b1, 3'b000, 32'h103, 32'h7F,      32'd0,        1'b0);
    dir(1, "lb_w0",  1'b1, 1'b0, 3'b000, 32'h103, 32'd0,       32'h0000007F, 1'b0);

    rst_test(0);
    rst_test(1);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 300; n++) begin
        r  = $urandom_range(0, 7);
        rd = (r <= 3) || (r == 7);
        wr = (r >= 4);
        if ($urandom_range(0, 99) < 85) begin
          if (wr) f3 = 3'($urandom_range(0, 2));
          else begin
            r  = $urandom_range(0, 4);
            f3 = (r >= 3) ? 3'(r + 1) : 3'(r);
          end
        end else begin
          f3 = 3'($urandom);
        end
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_acc(k, rd, wr, f3, a, $urandom, got, ge, lat);
      end
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout got no finish, required finish before 60000 cycles");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the single-core RISC-V datapath. It sits at the far end of the memRead/memWrite request lines driven by the main decoder.
- Serves byte, half and word loads and stores with a configurable number of wait states. Returns a one-cycle ready pulse that the core uses to release its stall.
- Reports misaligned or unsupported accesses on err instead of touching memory.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two; AW = log2(DEPTH).
- WAIT_CYCLES, 2, extra BUSY cycles per access; legal range 0..15.
- INIT_FILE, "dmem.hex", hex image used only when DMEM_INIT_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- memRead  in  1  load request
- memWrite  in  1  store request
- funct3  in  3  access size/sign (RV32I encoding)
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  load result, sign/zero-extended
- ready  out  1  one-cycle completion pulse
- err  out  1  misaligned/unsupported access, valid with ready

Behaviour:
- Reset: state=IDLE, ready=0, err=0, rdata=0, internal latches cleared. Memory array is not cleared.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If memRead|memWrite, latch memWrite, funct3, addr and wdata. Load the wait counter with WAIT_CYCLES and go to BUSY.
  - If both memRead and memWrite are high, the access is a store and the read is ignored.
- BUSY:
  - Counter decrements each cycle.
  - Goes to DONE on the edge where the counter equals 0. With WAIT_CYCLES=0, BUSY lasts exactly 1 cycle.
- DONE:
  - ready=1 for exactly one cycle, then IDLE.
  - Requests present during BUSY or DONE are ignored; the core holds its request until ready.
  - Earliest next acceptance is the cycle after DONE.
- Latency from the acceptance cycle to ready high: WAIT_CYCLES+2 cycles.
- Commit timing:
  - Stores commit on the BUSY->DONE edge.
  - Load data is registered into rdata on the same edge.
  - rdata holds until the next completed load; stores and errors leave rdata at 0 for that response.
- Word index is addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Loads:
  - 000 LB: byte addr[1:0], sign-extended.
  - 001 LH: half addr[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU and 101 LHU: zero-extended.
- Stores:
  - 000 SB: writes wdata[7:0] to the lane selected by addr[1:0].
  - 001 SH: writes wdata[15:0] to the half selected by addr[1].
  - 010 SW: writes the full word.
  - Unselected byte lanes are unchanged.
- Errors:
  - Half access with addr[0]=1, word access with addr[1:0]!=0, or any other funct3 (loads 011/110/111, stores >=011).
  - Response: no memory write, rdata=0, err=1 together with ready, same latency.
- err is 0 whenever ready is 0.
- Reset mid-operation: rst has priority on any edge. The FSM returns to IDLE and no ready pulse is produced. A store pending in BUSY is not committed, including when rst coincides with the BUSY->DONE edge.

Optional Feature:
- DMEM_INIT_EN defined: the memory array is preloaded at elaboration from INIT_FILE (hex, one 32-bit word per line). rst still does not alter array contents.
- DMEM_INIT_EN undefined: no preload; array contents are X until written, and the bench must write before reading.

Test Plan:
- WAIT_CYCLES=2: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> each ready rises exactly 4 cycles after acceptance; rdata=0xDEADBEEF, err=0.
- After word 0x10=0xDEADBEEF: SB addr=0x11 wdata=0x80, then LB addr=0x11 -> rdata=0xFFFFFF80; LBU addr=0x11 -> 0x00000080; LW addr=0x10 -> 0xDEAD80EF.
- SH addr=0x22 wdata=0x8001, then LH addr=0x22 -> 0xFFFF8001; LHU -> 0x00008001; LW addr=0x20 -> upper half 0x8001, lower half unchanged.
- LW addr=0x13 and SH addr=0x21 wdata=0x1234 -> ready with err=1, rdata=0; a following LW addr=0x20 shows its word unchanged.
- memRead=memWrite=1 with SW addr=0x30 wdata=0x5 -> treated as store; LW addr=0x30 -> 0x00000005.
- Reset mid-operation: SW addr=0x40 wdata=0x1111 accepted, rst pulsed in its BUSY cycle -> no ready pulse, outputs 0; LW addr=0x40 returns the prior value. Repeat with WAIT_CYCLES=0 and rst on the BUSY->DONE edge -> same result.
